pressure_limit_bank: RTL and testbench
======================================

// Module: pressure_limit_bank
// PURPOSE
//  Multi-channel successor to the single-key pressure-limit flag of the chamber controller.
//  Each channel turns a raw operator key into a registered WITHIN/BEYOND limit flag. Each
//  channel has a debounce filter, rising-edge (press) detection, a selectable toggle or level
//  mode, a per-channel clear, and an optional auto-return timeout.
//  Sits between the key inputs and the pressure sequencer, which consumes limit/any_limit.
// PARAMETERS
//  CHANNELS  2   number of independent key/limit channels (>=1)
//  DEBOUNCE  4   consecutive mismatching cycles before filtered key follows raw key (>=1)
//  HOLD      0   cycles BEYOND may persist before auto-return to WITHIN; 0 = disabled
//  CNT_W     16  width of the per-channel hold counter; HOLD must be < 2**CNT_W
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         synchronous, active-high reset
//  key          in   CHANNELS  raw key per channel; already synchronous to clk
//  mode         in   1         0 = toggle on press, 1 = level (limit follows filtered key)
//  clear        in   CHANNELS  force channel to WITHIN; one-cycle or held
//  limit        out  CHANNELS  per-channel state, 1 = BEYOND, registered
//  limit_event  out  CHANNELS  1-cycle pulse in the first cycle limit shows a new value
//  timeout      out  CHANNELS  1-cycle pulse in the first cycle after a HOLD auto-return
//  any_limit    out  1         OR of limit; combinational from registers only
// BEHAVIOUR
//  Reset
//  - Sampled at posedge.
//  - Clears to 0: limit, limit_event, timeout, filtered key, debounce counter, hold counter.
//  - Reset overrides every other input, including mid-debounce and mid-hold.
//  Debounce, per channel, each posedge
//  - If key != filt: when dcnt==DEBOUNCE-1, filt<=key and dcnt<=0; otherwise dcnt<=dcnt+1.
//  - If key == filt: dcnt<=0. Any glitch shorter than DEBOUNCE cycles is discarded.
//  - A press is the posedge at which filt goes 0->1.
//  - A key raised before edge 1 and held sets filt at edge DEBOUNCE.
//  Limit FSM, per channel, states WITHIN(0) and BEYOND(1)
//  - Updates at the edge after the press is detected, so toggle latency is DEBOUNCE+1 edges
//    from key assertion.
//  - Priority, highest first: reset > clear > HOLD expiry > mode rule.
//  - Toggle mode: a press flips the state. A held key flips exactly once; key release has no
//    effect.
//  - Level mode: state <= filt (one-edge delay).
//  - Clear: state <= WITHIN; hold counter <= 0. A press in the same cycle is dropped.
//  Hold counter, per channel
//  - Counts edges spent in BEYOND; it is 0 while in WITHIN.
//  - If HOLD!=0 and hcnt==HOLD-1 while BEYOND: state <= WITHIN, hcnt <= 0, timeout pulses.
//  - In level mode with filt still 1, re-entry to BEYOND requires a new filt 0->1.
//  - Expiry and press in the same cycle: the result is WITHIN, with no double toggle.
//  Events
//  - limit_event[i] = 1 for exactly one cycle whenever limit[i] changed at the previous
//    edge, whether from press, level change, clear, or timeout.
//  - limit_event and timeout are never set by reset.
//  - Clear while already WITHIN produces no limit_event.
//  Mode
//  - A mode change is effective at the next edge and does not itself alter any state.
//  Channels
//  - Fully independent; simultaneous activity on all channels is legal.
// TESTING
//  1) DEBOUNCE=4, toggle: key[0] high for 10 cycles -> limit[0] 0->1 at edge 5, limit_event[0]
//     pulses once; release -> no change; second 10-cycle press -> limit[0]=0.
//  2) Glitch: key[1] high for 3 cycles, low 5 cycles -> limit[1] stays 0, no limit_event.
//  3) Level mode: key[0] high 8 cycles -> limit[0]=1 from edge 5 until 5 edges after release;
//     any_limit tracks it.
//  4) HOLD=6, toggle: one press -> limit=1 for exactly 6 cycles, then 0 with timeout and
//     limit_event pulsing together once.
//  5) clear[0] asserted on the same edge the press is detected -> limit[0] stays 0, no event;
//     clear while BEYOND -> 0 next edge, event pulse.
//  6) reset asserted mid-debounce (dcnt=2) and mid-hold -> all outputs 0 next edge; a fresh
//     press after reset needs the full DEBOUNCE+1 edges.

Source files
------------

// File: rtl/pressure_limit_bank.sv
// Bank of debounced operator-key channels, each producing a registered WITHIN/BEYOND
// pressure-limit flag with toggle/level modes, per-channel clear and optional auto-return.
module pressure_limit_bank #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HOLD     = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] key,
  input  logic                mode,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] limit,
  output logic [CHANNELS-1:0] limit_event,
  output logic [CHANNELS-1:0] timeout,
  output logic                any_limit
);

  localparam int unsigned      DW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0]    DLAST = DW'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] HLAST = CNT_W'((HOLD == 0) ? 0 : HOLD - 1);
  localparam bit               HOLD_EN = (HOLD != 0);

  typedef enum logic {
    WITHIN = 1'b0,
    BEYOND = 1'b1
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q, state_nx;
    logic [DW-1:0]    dcnt_q, dcnt_nx;
    logic [CNT_W-1:0] hcnt_q, hcnt_nx;
    logic             filt_q, filt_nx, filt_prev_q;
    logic             block_q, block_nx;
    logic             evt_q, evt_nx;
    logic             tmo_q, tmo_nx;
    logic             press, expire;

    // Debounce, press detection and limit next-state.
    always_comb begin
      dcnt_nx  = '0;
      filt_nx  = filt_q;
      state_nx = state_q;
      hcnt_nx  = '0;
      tmo_nx   = 1'b0;
      // A level-mode re-entry after auto-return waits for the filtered key to drop.
      block_nx = block_q & filt_q;
      press    = filt_q & ~filt_prev_q;
      expire   = HOLD_EN && (state_q == BEYOND) && (hcnt_q == HLAST);

      if (key[i] != filt_q) begin
        if (dcnt_q == DLAST) filt_nx = key[i];
        else                 dcnt_nx = dcnt_q + DW'(1);
      end

      if (clear[i]) begin
        state_nx = WITHIN;
      end else if (expire) begin
        state_nx = WITHIN;
        tmo_nx   = 1'b1;
        block_nx = 1'b1;
      end else if (mode) begin
        state_nx = (filt_q && !block_q) ? BEYOND : WITHIN;
      end else if (press) begin
        state_nx = (state_q == BEYOND) ? WITHIN : BEYOND;
      end

      if (HOLD_EN && state_q == BEYOND && state_nx == BEYOND) hcnt_nx = hcnt_q + CNT_W'(1);
      evt_nx = (state_nx != state_q);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q     <= WITHIN;
        dcnt_q      <= '0;
        hcnt_q      <= '0;
        filt_q      <= 1'b0;
        filt_prev_q <= 1'b0;
        block_q     <= 1'b0;
        evt_q       <= 1'b0;
        tmo_q       <= 1'b0;
      end else begin
        state_q     <= state_nx;
        dcnt_q      <= dcnt_nx;
        hcnt_q      <= hcnt_nx;
        filt_q      <= filt_nx;
        filt_prev_q <= filt_q;
        block_q     <= block_nx;
        evt_q       <= evt_nx;
        tmo_q       <= tmo_nx;
      end
    end

    assign limit[i]       = (state_q == BEYOND);
    assign limit_event[i] = evt_q;
    assign timeout[i]     = tmo_q;
  end

  assign any_limit = |limit;

endmodule

// File: tb/tb_pressure_limit_bank.sv
// Self-checking bench: table vectors, directed corner sequences and random stimulus
// against a sample-history reference model, on a HOLD=0 and a HOLD=6 instance.
module tb_pressure_limit_bank;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] key = '0;
  logic       mode = 1'b0;
  logic [1:0] clear = '0;
  logic [1:0] lim0, evt0, tmo0, lim6, evt6, tmo6;
  logic       any0, any6;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pressure_limit_bank #(.CHANNELS(2), .DEBOUNCE(DEB), .HOLD(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .key(key), .mode(mode), .clear(clear),
    .limit(lim0), .limit_event(evt0), .timeout(tmo0), .any_limit(any0));

  pressure_limit_bank #(.CHANNELS(2), .DEBOUNCE(DEB), .HOLD(6), .CNT_W(16)) u_dut6 (
    .clk(clk), .reset(reset), .key(key), .mode(mode), .clear(clear),
    .limit(lim6), .limit_event(evt6), .timeout(tmo6), .any_limit(any6));

  // Reference model: index [dut][channel]; filter decided from recent raw samples.
  logic [3:0] m_hist [2][2];
  int         m_nv   [2][2];
  bit         m_filt [2][2];
  bit         m_prev [2][2];
  bit         m_lim  [2][2];
  bit         m_blk  [2][2];
  bit         m_evt  [2][2];
  bit         m_tmo  [2][2];
  int         m_age  [2][2];

  function automatic void model_edge(input bit r, input logic [1:0] k, input bit md,
                                     input logic [1:0] cl);
    int  hold;
    bit  press, expire, nl;
    for (int d = 0; d < 2; d++) begin
      hold = (d == 1) ? 6 : 0;
      for (int c = 0; c < 2; c++) begin
        if (r) begin
          m_hist[d][c] = '0; m_nv[d][c] = 0; m_filt[d][c] = 0; m_prev[d][c] = 0;
          m_lim[d][c] = 0; m_blk[d][c] = 0; m_evt[d][c] = 0; m_tmo[d][c] = 0;
          m_age[d][c] = 0;
        end else begin
          press  = m_filt[d][c] && !m_prev[d][c];
          expire = (hold != 0) && m_lim[d][c] && (m_age[d][c] == hold);
          if (cl[c])      nl = 0;
          else if (expire) nl = 0;
          else if (md)    nl = m_filt[d][c] && !m_blk[d][c];
          else            nl = press ? !m_lim[d][c] : m_lim[d][c];
          m_evt[d][c] = (nl != m_lim[d][c]);
          m_tmo[d][c] = !cl[c] && expire;
          if (!cl[c] && expire)  m_blk[d][c] = 1;
          else if (!m_filt[d][c]) m_blk[d][c] = 0;
          m_age[d][c] = nl ? (m_lim[d][c] ? m_age[d][c] + 1 : 1) : 0;
          m_lim[d][c] = nl;
          m_prev[d][c] = m_filt[d][c];
          m_hist[d][c] = {m_hist[d][c][2:0], k[c]};
          m_nv[d][c] = (m_nv[d][c] < DEB) ? m_nv[d][c] + 1 : DEB;
          if (m_nv[d][c] == DEB && m_hist[d][c] == (m_filt[d][c] ? 4'b0000 : 4'b1111)) begin
            m_filt[d][c] = !m_filt[d][c];
            m_nv[d][c] = 0;
          end
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model, compare both instances against it.
  task automatic cycle(input bit r, input logic [1:0] k, input bit md, input logic [1:0] cl);
    logic [1:0] el, ee, et;
    reset = r; key = k; mode = md; clear = cl;
    @(posedge clk);
    model_edge(r, k, md, cl);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      el = {m_lim[d][1], m_lim[d][0]};
      ee = {m_evt[d][1], m_evt[d][0]};
      et = {m_tmo[d][1], m_tmo[d][0]};
      chk($sformatf("model dut%0d limit", d), 32'(d == 0 ? lim0 : lim6), 32'(el));
      chk($sformatf("model dut%0d limit_event", d), 32'(d == 0 ? evt0 : evt6), 32'(ee));
      chk($sformatf("model dut%0d timeout", d), 32'(d == 0 ? tmo0 : tmo6), 32'(et));
      chk($sformatf("model dut%0d any_limit", d), 32'(d == 0 ? any0 : any6), 32'(|el));
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] k;
    logic       md;
    logic [1:0] cl;
    logic [1:0] lim;
    logic [1:0] evt;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int         ecount;
    logic [15:0] vl, va;
    logic [19:0] hl, ht, he;
    logic [1:0] rk, rc;
    bit         rm, rr;

    // Toggle-mode press of ch0 on the HOLD=0 instance, expected values per edge.
    tbl[0] = '{1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00};
    for (int i = 1; i <= 10; i++)
      tbl[i] = '{1'b0, 2'b01, 1'b0, 2'b00, (i >= 5) ? 2'b01 : 2'b00, (i == 5) ? 2'b01 : 2'b00};
    for (int i = 11; i <= 16; i++)
      tbl[i] = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00};

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].rst, tbl[i].k, tbl[i].md, tbl[i].cl);
      chk($sformatf("tbl[%0d] limit", i), 32'(lim0), 32'(tbl[i].lim));
      chk($sformatf("tbl[%0d] limit_event", i), 32'(evt0), 32'(tbl[i].evt));
      chk($sformatf("tbl[%0d] timeout", i), 32'(tmo0), 32'd0);
    end

    // Second 10-cycle press toggles back to WITHIN.
    for (int i = 0; i < 10; i++) cycle(1'b0, 2'b01, 1'b0, 2'b00);
    chk("second press limit0", 32'(lim0[0]), 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'b00, 1'b0, 2'b00);

    // Glitch on ch1 shorter than the debounce window.
    ecount = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, (i < 3) ? 2'b10 : 2'b00, 1'b0, 2'b00);
      ecount += int'(evt0[1]);
    end
    chk("glitch limit1", 32'(lim0[1]), 32'd0);
    chk("glitch events1", 32'(ecount), 32'd0);

    // Level mode: 8-cycle key on ch0.
    cycle(1'b1, 2'b00, 1'b1, 2'b00);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, (i < 8) ? 2'b01 : 2'b00, 1'b1, 2'b00);
      vl[i] = lim0[0];
      va[i] = any0;
    end
    chk("level limit0 trace", 32'(vl), 32'h0FF0);
    chk("level any_limit trace", 32'(va), 32'h0FF0);

    // HOLD=6 auto-return after a single toggle press.
    cycle(1'b1, 2'b00, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, (i < 10) ? 2'b01 : 2'b00, 1'b0, 2'b00);
      hl[i] = lim6[0];
      ht[i] = tmo6[0];
      he[i] = evt6[0];
    end
    chk("hold limit0 trace", 32'(hl), 32'h003F0);
    chk("hold timeout trace", 32'(ht), 32'h00400);
    chk("hold event trace", 32'(he), 32'h00410);

    // Clear held across the press detection drops the press.
    cycle(1'b1, 2'b00, 1'b0, 2'b00);
    ecount = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 2'b01, 1'b0, (i == 4 || i == 5) ? 2'b01 : 2'b00);
      ecount += int'(evt0[0]);
    end
    chk("clear-at-press limit0", 32'(lim0[0]), 32'd0);
    chk("clear-at-press events0", 32'(ecount), 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'b00, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) cycle(1'b0, 2'b01, 1'b0, 2'b00);
    chk("re-press limit0", 32'(lim0[0]), 32'd1);
    cycle(1'b0, 2'b01, 1'b0, 2'b01);
    chk("clear beyond limit0", 32'(lim0[0]), 32'd0);
    chk("clear beyond event0", 32'(evt0[0]), 32'd1);
    cycle(1'b0, 2'b01, 1'b0, 2'b00);
    chk("clear event one-shot", 32'(evt0[0]), 32'd0);

    // Reset mid-debounce, then a full-latency fresh press, then reset mid-hold.
    cycle(1'b1, 2'b00, 1'b0, 2'b00);
    cycle(1'b0, 2'b01, 1'b0, 2'b00);
    cycle(1'b0, 2'b01, 1'b0, 2'b00);
    cycle(1'b1, 2'b01, 1'b0, 2'b00);
    chk("reset mid-debounce outputs", 32'({lim0, evt0, tmo0, any0}), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 2'b01, 1'b0, 2'b00);
      chk($sformatf("fresh press edge %0d", i), 32'(lim0[0]), 32'(i == 5));
    end
    cycle(1'b0, 2'b01, 1'b0, 2'b00);
    cycle(1'b0, 2'b01, 1'b0, 2'b00);
    chk("mid-hold beyond", 32'(lim6[0]), 32'd1);
    cycle(1'b1, 2'b00, 1'b0, 2'b00);
    chk("reset mid-hold outputs", 32'({lim6, evt6, tmo6, any6}), 32'd0);
    cycle(1'b0, 2'b00, 1'b0, 2'b00);
    chk("no event after reset", 32'({evt0, tmo0, evt6, tmo6}), 32'd0);

    // Random traffic against the model.
    rk = '0; rm = 1'b0;
    cycle(1'b1, 2'b00, 1'b0, 2'b00);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 2; c++) if ($urandom_range(4) == 0) rk[c] = ~rk[c];
      if ($urandom_range(49) == 0) rm = ~rm;
      rc = {($urandom_range(39) == 0), ($urandom_range(39) == 0)};
      rr = ($urandom_range(499) == 0);
      cycle(rr, rk, rm, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
